// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter among NREQ sources.
// Each byte is issued with a write_en strobe and paced by the transmitter's tx_busy rise and fall.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned BUSY_TO = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        write_data,
    output logic              write_en,
    input  logic              tx_busy,
    output logic              err_timeout
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(BUSY_TO) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  ready_q, ready_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             to_q, to_d;

    logic [7:0]       req_byte [NREQ];
    logic             rr_found;
    logic [PTR_W-1:0] rr_idx;
    logic             issue;
    logic             done;
    logic [PTR_W-1:0] sel;

    assign grant       = grant_q;
    assign req_ready   = ready_q;
    assign write_data  = wdata_q;
    assign write_en    = we_q;
    assign err_timeout = to_q;

    // Unpack the flat request data bus into per-source bytes
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin search starting just after the last owner
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((32'(ptr_q) + k) % NREQ);
            if (!rr_found && req_valid[idx]) begin
                rr_found = 1'b1;
                rr_idx   = idx;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ready_d = '0;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        to_d    = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        sel     = ptr_q;

        case (state_q)
            IDLE: begin
                if (lock_q) begin
                    sel   = ptr_q;
                    issue = req_valid[ptr_q];
                end else begin
                    sel   = rr_idx;
                    issue = rr_found;
                end
                if (issue) begin
                    ptr_d   = sel;
                    lock_d  = 1'b1;
                    grant_d = NREQ'(1) << sel;
                    ready_d = NREQ'(1) << sel;
                    wdata_d = req_byte[sel];
                    we_d    = 1'b1;
                    last_d  = req_last[sel];
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                    to_d = 1'b1;
                    done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy && busy_q) begin
                    done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A byte completes on tx_busy fall or timeout; only a last byte ends the message
        if (done) begin
            state_d = IDLE;
            if (last_q) begin
                lock_d  = 1'b0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NREQ - 1);
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            ready_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= tx_busy;
            grant_q <= grant_d;
            ready_q <= ready_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte queues, a UART TX model and a message-level
// round-robin scoreboard, plus scenario table and directed corner sequences.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int BUSY_TO = 16;
    localparam int DEPTH   = 256;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        write_data;
    logic              write_en;
    logic              tx_busy;
    logic              err_timeout;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .write_data (write_data),
        .write_en   (write_en),
        .tx_busy    (tx_busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TX model: busy rises 1 clk after write_en and stays high busy_len cycles
    logic tx_man;
    logic tx_busy_man;
    logic m_busy;
    int   m_cnt;
    int   busy_len;
    assign tx_busy = tx_man ? tx_busy_man : m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (write_en) begin
            m_busy <= 1'b1;
            m_cnt  <= busy_len - 1;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    logic [8:0] sbuf [NREQ][DEPTH];
    int         shead [NREQ];
    int         stail [NREQ];

    int n_checks;
    int n_errors;
    int m_ptr;
    int m_owner;
    logic prev_we;
    bit rand_busy;
    bit allow_to;
    int ord_log [64];
    int ord_n;
    int we_cnt;

    typedef struct {
        logic [3:0]  mask;
        int          len;
        int          nmsg;
        int          n_ord;
        logic [15:0] order;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [NREQ-1:0] oh(input int i);
        if (i < 0) return '0;
        return NREQ'(1) << i;
    endfunction

    function automatic int dec(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (shead[i] < stail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = sbuf[i][shead[i]][7:0];
                req_last[i]        = sbuf[i][shead[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        if (stail[s] < DEPTH) begin
            sbuf[s][stail[s]] = {l, d};
            stail[s]++;
        end
    endtask

    // One clock: sample at negedge, score any issued byte, pop accepted bytes, re-drive sources
    task automatic step();
        int w;
        logic [NREQ-1:0] eo;
        @(negedge clk);
        if (!write_en) chk("ready_without_we", 32'(req_ready), 32'(0));
        if (!allow_to) chk("unexpected_timeout", 32'(err_timeout), 32'(0));
        if (write_en) begin
            chk("we_width", 32'(prev_we), 32'(0));
            if (m_owner < 0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                chk("issue_has_valid", 32'(w >= 0), 32'(1));
                if (w >= 0) begin
                    m_owner = w;
                    m_ptr   = w;
                end
            end
            eo = oh(m_owner);
            chk("grant_at_we", 32'(grant), 32'(eo));
            chk("ready_at_we", 32'(req_ready), 32'(eo));
            if (m_owner >= 0 && shead[m_owner] < stail[m_owner]) begin
                chk("write_data", 32'(write_data), 32'(sbuf[m_owner][shead[m_owner]][7:0]));
                if (sbuf[m_owner][shead[m_owner]][8]) m_owner = -1;
            end
            if (ord_n < 64) begin
                ord_log[ord_n] = dec(grant);
                ord_n++;
            end
            we_cnt++;
            if (rand_busy) busy_len = $urandom_range(1, 12);
        end
        prev_we = write_en;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && shead[i] < stail[i]) shead[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            shead[i] = 0;
            stail[i] = 0;
        end
        drive();
        m_ptr   = NREQ - 1;
        m_owner = -1;
        prev_we = 1'b0;
        #1;
        chk("reset_async", 32'({grant, req_ready, write_data, write_en, err_timeout}), 32'(0));
        repeat (3) begin
            step();
            chk("reset_outputs", 32'({grant, req_ready, write_data, write_en, err_timeout}), 32'(0));
        end
        rst_n  = 1'b1;
        ord_n  = 0;
        we_cnt = 0;
    endtask

    task automatic wait_we(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!write_en && n < 50);
        chk(nm, 32'(write_en), 32'(1));
    endtask

    task automatic wait_to(input string nm, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!err_timeout && cycles < 40);
        chk(nm, 32'(err_timeout), 32'(1));
    endtask

    task automatic wait_drain(input string nm);
        int  n;
        bit  empty;
        n = 0;
        empty = 1'b0;
        while (n < 4000) begin
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (shead[i] < stail[i]) empty = 1'b0;
            if (empty) break;
            step();
            n++;
        end
        chk(nm, 32'(empty), 32'(1));
        repeat (16) step();
    endtask

    initial begin
        int cyc;
        int p;
        int tot;
        int len;
        logic [15:0] ov;
        logic [3:0]  msk;

        n_checks = 0;
        n_errors = 0;
        tx_man = 1'b0;
        tx_busy_man = 1'b0;
        busy_len = 10;
        rand_busy = 1'b0;
        allow_to = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        ord_n = 0;
        we_cnt = 0;

        // Scenario table: sources in mask each load nmsg messages of len bytes at once
        tbl[0] = '{4'b0001, 3, 1, 1, 16'h0000};
        tbl[1] = '{4'b0101, 2, 1, 2, 16'h0020};
        tbl[2] = '{4'b1111, 1, 2, 4, 16'h3210};
        tbl[3] = '{4'b1000, 2, 1, 1, 16'h0003};
        tbl[4] = '{4'b0110, 3, 2, 2, 16'h0021};
        tbl[5] = '{4'b1010, 1, 3, 2, 16'h0031};

        // Three-byte message from req0
        do_reset();
        push(0, 8'h48, 1'b0);
        push(0, 8'h49, 1'b0);
        push(0, 8'h0A, 1'b1);
        drive();
        wait_we("t1_first_we");
        chk("t1_grant_first", 32'(grant), 32'(4'b0001));
        cyc = 0;
        while (we_cnt < 3 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t1_we_count", 32'(we_cnt), 32'(3));
        chk("t1_grant_last", 32'(grant), 32'(4'b0001));
        repeat (20) step();
        chk("t1_grant_release", 32'(grant), 32'(0));
        chk("t1_total", 32'(we_cnt), 32'(3));

        for (int e = 0; e < 6; e++) begin
            do_reset();
            msk = tbl[e].mask;
            for (int i = 0; i < NREQ; i++) begin
                if (msk[i]) begin
                    for (int m = 0; m < tbl[e].nmsg; m++)
                        for (int k = 0; k < tbl[e].len; k++)
                            push(i, 8'(i*64 + m*8 + k), k == tbl[e].len - 1);
                end
            end
            drive();
            wait_drain($sformatf("tbl%0d_drain", e));
            chk($sformatf("tbl%0d_bytes", e), 32'(ord_n), 32'(tbl[e].nmsg * tbl[e].n_ord * tbl[e].len));
            ov = tbl[e].order;
            p = 0;
            for (int r = 0; r < tbl[e].nmsg; r++)
                for (int q = 0; q < tbl[e].n_ord; q++)
                    for (int k = 0; k < tbl[e].len; k++) begin
                        if (p < ord_n)
                            chk($sformatf("tbl%0d_byte%0d_src", e, p), 32'(ord_log[p]), 32'(ov[4*q +: 4]));
                        p++;
                    end
            chk($sformatf("tbl%0d_final_grant", e), 32'(grant), 32'(0));
        end

        // tx_busy never rises: each byte of req1 times out, lock held until the last one
        tx_man = 1'b1;
        tx_busy_man = 1'b0;
        allow_to = 1'b1;
        do_reset();
        push(1, 8'h5A, 1'b0);
        push(1, 8'hA5, 1'b1);
        drive();
        wait_we("t4_first_we");
        wait_to("t4_timeout1", cyc);
        chk("t4_timeout_dist", 32'(cyc), 32'(BUSY_TO));
        chk("t4_grant_kept", 32'(grant), 32'(4'b0010));
        step();
        chk("t4_next_we", 32'(write_en), 32'(1));
        chk("t4_next_data", 32'(write_data), 32'(8'hA5));
        wait_to("t4_timeout2", cyc);
        chk("t4_grant_release", 32'(grant), 32'(0));
        step();
        chk("t4_timeout_width", 32'(err_timeout), 32'(0));
        allow_to = 1'b0;

        // Reset in the middle of req3's message, then a lone req1 byte
        tx_man = 1'b0;
        busy_len = 10;
        do_reset();
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b1);
        drive();
        wait_we("t5_first_we");
        repeat (4) step();
        do_reset();
        push(1, 8'h11, 1'b1);
        drive();
        step();
        chk("t5_we_after_reset", 32'(write_en), 32'(1));
        chk("t5_grant_after_reset", 32'(grant), 32'(4'b0010));
        chk("t5_data_after_reset", 32'(write_data), 32'(8'h11));
        wait_drain("t5_drain");

        // tx_busy falls in the same cycle req2 raises valid
        tx_man = 1'b1;
        tx_busy_man = 1'b0;
        do_reset();
        push(0, 8'hC3, 1'b1);
        drive();
        wait_we("t6_first_we");
        tx_busy_man = 1'b1;
        repeat (3) step();
        tx_busy_man = 1'b0;
        push(2, 8'h7E, 1'b1);
        drive();
        step();
        chk("t6_we_fall_plus1", 32'(write_en), 32'(0));
        step();
        chk("t6_we_fall_plus2", 32'(write_en), 32'(1));
        chk("t6_data", 32'(write_data), 32'(8'h7E));
        chk("t6_grant", 32'(grant), 32'(4'b0100));
        step();
        chk("t6_we_single", 32'(write_en), 32'(0));

        // Random message arrivals with random busy lengths
        tx_man = 1'b0;
        rand_busy = 1'b1;
        busy_len = $urandom_range(1, 12);
        do_reset();
        tot = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (shead[i] == stail[i] && stail[i] < DEPTH - 8 && $urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 3);
                    for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
                    tot += len;
                end
            end
            drive();
            step();
        end
        wait_drain("rand_drain");
        chk("rand_byte_count", 32'(we_cnt), 32'(tot));
        chk("rand_final_grant", 32'(grant), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
